// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, FSM type and round-function helpers shared by the round engine and key schedule.
package aes_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;
  localparam int NR = 10;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] round_key(input logic [1407:0] ek, input logic [3:0] idx);
    return ek[1407 - 128 * int'(idx) -: 128];
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = SBOX[2047 - 8 * int'(din) -: 8];
endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryption, one round per clock over a pre-expanded key schedule.
module aes_round_engine
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [1407:0] exp_key,
  input  logic          start_enc,
  input  logic [127:0]  plaintext,
  output logic          busy,
  output logic          enc_done,
  output logic [127:0]  ciphertext,
  output logic          start_err
);
  fsm_t         st;
  logic [3:0]   round_cnt;
  logic [127:0] state_reg, sub, shifted, mixed;
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.din(state_reg[8*i +: 8]), .dout(sub[8*i +: 8]));
  end
  assign shifted = shift_rows(sub);
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      round_cnt  <= '0;
      state_reg  <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      enc_done   <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      enc_done  <= 1'b0;
      start_err <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start_enc && key_valid) begin
            state_reg <= plaintext ^ round_key(exp_key, 4'd0);
            round_cnt <= 4'd1;
            busy      <= 1'b1;
            st        <= S_ROUND;
          end else if (start_enc) begin
            start_err <= 1'b1;
          end
        end
        S_ROUND: begin
          state_reg <= mixed ^ round_key(exp_key, round_cnt);
          round_cnt <= round_cnt + 4'd1;
          if (round_cnt == 4'(NR - 1)) st <= S_FINAL;
        end
        S_FINAL: begin
          ciphertext <= shifted ^ round_key(exp_key, 4'(NR));
          enc_done   <= 1'b1;
          st         <= S_DONE;
        end
        S_DONE: begin
          busy <= 1'b0;
          st   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: FIPS-197 vectors, protocol corner cases and random blocks against a software AES model.
module tb_aes_round_engine;
  logic          clk = 1'b0, rst = 1'b1, key_valid = 1'b0, start_enc = 1'b0;
  logic [1407:0] exp_key = '0;
  logic [127:0]  plaintext = '0;
  logic          busy, enc_done, start_err;
  logic [127:0]  ciphertext;
  int            total = 0, bad = 0;
  logic [7:0]    sb [256];
  typedef struct {logic [127:0] key, pt, ct;} vec_t;
  vec_t          vecs [3];

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .exp_key(exp_key),
    .start_enc(start_enc), .plaintext(plaintext), .busy(busy),
    .enc_done(enc_done), .ciphertext(ciphertext), .start_err(start_err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ek;
    rc = 8'h01;
    ek = '0;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[127 - 32 * i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end
        w[i] = w[i-4] ^ t;
      end
      ek[1407 - 32 * i -: 32] = w[i];
    end
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] ek;
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [127:0]  o;
    ek = expand(key);
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ ek[1407 - 8 * b -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[(b % 4) + 4 * ((b / 4 + b % 4) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 10 ? t[4*c+r] :
                      gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4])
                     ^ ek[1407 - 128 * rd - 8 * (4 * c + r) -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127 - 8 * b -: 8] = s[b];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for enc_done; lat is the number of samples since the accept edge (1 = right after it).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!enc_done && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat);
    exp_key   = expand(key);
    key_valid = 1'b1;
    plaintext = pt;
    start_enc = 1'b1;
    tick;
    start_enc = 1'b0;
    wait_done(lat);
    ct = ciphertext;
    tick;
  endtask

  int            run = 0;
  bit            abort = 1'b0;
  logic          prev_done = 1'b0;
  logic [1407:0] prev_key = '0;
  always @(negedge clk) begin
    if (busy === 1'b1) run++;
    else begin
      if (run != 0 && !abort) chk("busy_len", 128'(run), 128'd11);
      run = 0;
      abort = 1'b0;
    end
    if (rst) abort = 1'b1;
    if (enc_done === 1'b1) chk("done_pulse", {126'd0, prev_done, busy}, 128'd1);
    if (busy === 1'b1 && run > 1 && exp_key !== prev_key) begin
      bad++;
      $display("FAIL key_stable: exp_key changed while busy");
    end
    prev_done = enc_done;
    prev_key  = exp_key;
  end

  initial begin
    logic [7:0]   inv, xb;
    logic [127:0] ct, key, pt;
    int           lat, errs, seen;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    tick;
    tick;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(enc_done), 128'd0);
    chk("rst_err", 128'(start_err), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    rst = 1'b0;

    start_enc = 1'b1;
    tick;
    start_enc = 1'b0;
    chk("err_pulse", 128'(start_err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    tick;
    chk("err_clear", 128'(start_err), 128'd0);
    chk("err_busy2", 128'(busy), 128'd0);
    chk("err_ct", ciphertext, 128'd0);

    for (int v = 0; v < 3; v++) begin
      run_block(vecs[v].key, vecs[v].pt, ct, lat);
      chk($sformatf("vec%0d_ct", v), ct, vecs[v].ct);
      chk($sformatf("vec%0d_lat", v), 128'(lat), 128'd11);
      chk($sformatf("vec%0d_idle", v), 128'(busy), 128'd0);
    end

    exp_key   = expand(vecs[1].key);
    plaintext = vecs[1].pt;
    start_enc = 1'b1;
    tick;
    wait_done(lat);
    chk("held1_ct", ciphertext, vecs[1].ct);
    chk("held1_lat", 128'(lat), 128'd11);
    chk("held1_err", 128'(start_err), 128'd0);
    tick;
    chk("held_gap", 128'(busy), 128'd0);
    tick;
    chk("held_reaccept", 128'(busy), 128'd1);
    start_enc = 1'b0;
    wait_done(lat);
    chk("held2_ct", ciphertext, vecs[1].ct);
    chk("held2_lat", 128'(lat), 128'd11);
    tick;

    exp_key   = expand(vecs[0].key);
    plaintext = vecs[0].pt;
    start_enc = 1'b1;
    tick;
    plaintext = ~vecs[0].pt;
    lat = 1;
    errs = 0;
    while (!enc_done && lat < 20) begin
      start_enc = (lat == 3 || lat == 7);
      tick;
      lat++;
      if (start_err) errs++;
    end
    start_enc = 1'b0;
    chk("repulse_ct", ciphertext, vecs[0].ct);
    chk("repulse_lat", 128'(lat), 128'd11);
    chk("repulse_err", 128'(errs), 128'd0);
    tick;

    run_block(vecs[1].key, vecs[1].pt, ct, lat);
    exp_key   = expand(vecs[0].key);
    plaintext = vecs[0].pt;
    start_enc = 1'b1;
    tick;
    start_enc = 1'b0;
    for (int n = 1; n < 5; n++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_ct", ciphertext, 128'd0);
    chk("abort_done", 128'(enc_done), 128'd0);
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      tick;
      if (enc_done || busy) seen++;
    end
    chk("abort_quiet", 128'(seen), 128'd0);
    run_block(vecs[0].key, vecs[0].pt, ct, lat);
    chk("post_abort_ct", ct, vecs[0].ct);
    chk("post_abort_lat", 128'(lat), 128'd11);

    for (int k = 0; k < 1000; k++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(key, pt, ct, lat);
      chk($sformatf("rand%0d_ct", k), ct, encrypt(key, pt));
      chk($sformatf("rand%0d_lat", k), 128'(lat), 128'd11);
    end

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
